skullfet_array_tester: RTL
==========================

Name: skullfet_array_tester

Overview:
- On-chip self-test engine for an array of N_CH SkullFET inverter cells in the user project area.
- Drives a fixed pattern sequence into the cells and waits a programmable settle time.
- Samples the cell outputs through a synchroniser and checks each sample against the bitwise inverse of the drive.
- Reports a 4-bit result code, an error count and a per-channel fail mask. Firmware reads these through the management core, replacing single-inverter GPIO loopback checks.

Parameters:
- N_CH, 8, number of inverter channels (>=2).
- SETTLE_CYCLES, 16, clock cycles between drive and check; includes synchroniser latency (>=3).
- ERR_W, 8, width of saturating error counter.

Ports:
- clk  input  1  system clock.
- resetb  input  1  asynchronous active-low reset.
- start  input  1  level-sampled; a high in IDLE or DONE begins a run.
- inv_out  input  N_CH  raw (asynchronous) outputs of the SkullFET cells.
- inv_in  output  N_CH  drive to the SkullFET cell inputs.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse on entry to DONE.
- pass  output  1  sticky; valid in DONE.
- err_count  output  ERR_W  total mismatching bits, saturating.
- fail_mask  output  N_CH  OR of mismatch bits over the run.
- result  output  4  status code.

Behaviour:
- Reset values: inv_in=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, result=4'h0; FSM in IDLE; synchroniser flops cleared.
- inv_out passes through a 2-flop synchroniser before any compare.
- Pattern table, NUM_PAT = 4+N_CH, PAT_W = clog2(NUM_PAT):
  - P0 = all 0.
  - P1 = all 1.
  - P2: bit i = i odd.
  - P3 = ~P2.
  - P(4+k) = walking one, only bit k set, for k = 0..N_CH-1.
- FSM states:
  - IDLE: on start=1 -> DRIVE. Clears err_count and fail_mask, pat_idx=0, result=4'h1, busy=1.
  - DRIVE (1 cycle): inv_in <= pattern[pat_idx]; settle counter loaded with SETTLE_CYCLES-1 -> SETTLE.
  - SETTLE: counter decrements each cycle; at 0 -> CHECK.
  - CHECK (1 cycle): mismatch = sync_out XNOR inv_in, i.e. a bit is bad when output equals input.
    - err_count += popcount(mismatch), saturating at 2^ERR_W-1.
    - fail_mask |= mismatch.
    - If pat_idx == NUM_PAT-1 -> DONE; else pat_idx++ and -> DRIVE.
  - DONE: inv_in <= 0; busy=0; done pulses for one cycle on entry.
    - pass = (fail_mask == 0).
    - result = 4'h5 on pass, 4'hE on fail. Outputs hold.
    - start=1 -> restart as from IDLE; counters are cleared in the same cycle.
- Per-pattern cost is SETTLE_CYCLES+2 cycles. The cycle start is sampled high to the done pulse is NUM_PAT*(SETTLE_CYCLES+2)+1 cycles.
- start while busy is ignored.
- Asserting resetb low mid-run aborts immediately to reset values; no partial results are retained.
- err_count saturation does not stop the run; fail_mask remains exact.

Optional Feature:
- Macro: SKULLFET_ARRAY_TESTER_FIRST_FAIL_EN.
- When defined:
  - Adds output first_fail_pat [PAT_W].
  - Reset value and value after each start: all ones.
  - Latched with pat_idx at the first CHECK that has a nonzero mismatch; never overwritten until the next start.
- When undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package skullfet_tester_pkg holds:
  - FSM state enum (IDLE, DRIVE, SETTLE, CHECK, DONE).
  - Result code constants RES_IDLE=4'h0, RES_BUSY=4'h1, RES_PASS=4'h5, RES_FAIL=4'hE.
  - Pattern class offsets (PAT_ZERO=0, PAT_ONE=1, PAT_ALT=2, PAT_NALT=3, PAT_WALK=4).
- One sub-module, skullfet_sync2: parametrised N-bit 2-flop synchroniser with async active-low reset.
- Pattern generation and popcount are combinational functions in the main module.

Test Plan:
- Ideal inverter model (inv_out = ~inv_in, 3-cycle delay), N_CH=8, SETTLE_CYCLES=4, start pulsed -> done at 73 cycles; pass=1, err_count=0, fail_mask=8'h00, result=4'h5, inv_in=0 afterwards.
- Channel 3 stuck high, others ideal -> mismatches in P1, P2 and P7. Expect err_count=3, fail_mask=8'h08, result=4'hE; first_fail_pat=1 when the macro is defined.
- All outputs stuck low, ERR_W=4 -> 72 raw mismatches. Expect err_count=4'hF (saturated), fail_mask=8'hFF, result=4'hE, run completes the full length.
- Ideal model but 6-cycle delay with SETTLE_CYCLES=4 -> stale samples produce failures. Expect pass=0, result=4'hE, fail_mask nonzero.
- resetb low during pattern 5 -> all outputs at reset values next edge. A start afterwards gives a full clean run ending pass=1.
- start held high through a run -> no restart while busy. Re-run begins the cycle after DONE entry, with counters cleared and result=4'h1.

Source files
------------

// File: rtl/skullfet_array_tester_pkg.sv
// skullfet_tester_pkg: FSM states, result codes and pattern class offsets for the SkullFET array tester.
package skullfet_tester_pkg;

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

    localparam logic [3:0] RES_IDLE = 4'h0;
    localparam logic [3:0] RES_BUSY = 4'h1;
    localparam logic [3:0] RES_PASS = 4'h5;
    localparam logic [3:0] RES_FAIL = 4'hE;

    localparam int PAT_ZERO = 0;
    localparam int PAT_ONE  = 1;
    localparam int PAT_ALT  = 2;
    localparam int PAT_NALT = 3;
    localparam int PAT_WALK = 4;

endpackage

// File: rtl/skullfet_array_tester_sync2.sv
// skullfet_sync2: N-bit two-flop synchroniser with asynchronous active-low reset.
module skullfet_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/skullfet_array_tester.sv
// skullfet_array_tester: drives a pattern sequence into N_CH inverter cells and checks each output is the inverse.
// Defining SKULLFET_ARRAY_TESTER_FIRST_FAIL_EN adds the first_fail_pat output.
module skullfet_array_tester
    import skullfet_tester_pkg::*;
#(
    parameter  int N_CH          = 8,
    parameter  int SETTLE_CYCLES = 16,
    parameter  int ERR_W         = 8,
    localparam int NUM_PAT       = 4 + N_CH,
    localparam int PAT_W         = $clog2(NUM_PAT)
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              start,
    input  logic [N_CH-1:0]   inv_out,
    output logic [N_CH-1:0]   inv_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [N_CH-1:0]   fail_mask,
    output logic [3:0]        result
`ifdef SKULLFET_ARRAY_TESTER_FIRST_FAIL_EN
    ,
    output logic [PAT_W-1:0]  first_fail_pat
`endif
);

    localparam int CW  = $clog2(N_CH + 1);
    localparam int SW  = (ERR_W > CW ? ERR_W : CW) + 1;
    localparam int CNW = $clog2(SETTLE_CYCLES);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    function automatic logic [N_CH-1:0] pattern(input logic [PAT_W-1:0] idx);
        logic [N_CH-1:0] alt;
        for (int i = 0; i < N_CH; i++) alt[i] = (i % 2 == 1);
        return idx == PAT_W'(PAT_ZERO) ? '0 :
               idx == PAT_W'(PAT_ONE)  ? '1 :
               idx == PAT_W'(PAT_ALT)  ? alt :
               idx == PAT_W'(PAT_NALT) ? ~alt :
               N_CH'(1) << (idx - PAT_W'(PAT_WALK));
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [N_CH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N_CH; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    state_t          state;
    logic [PAT_W-1:0] pat_idx;
    logic [CNW-1:0]  cnt;
    logic [N_CH-1:0] sync_out;
    logic [N_CH-1:0] mismatch;
    logic [N_CH-1:0] mask_next;
    logic [SW-1:0]   sum;
    logic [ERR_W-1:0] err_next;

    skullfet_sync2 #(.W(N_CH)) u_sync (
        .clk    (clk),
        .resetb (resetb),
        .d      (inv_out),
        .q      (sync_out)
    );

    // A cell is bad when its output equals its input.
    always_comb begin
        mismatch  = ~(sync_out ^ inv_in);
        mask_next = fail_mask | mismatch;
        sum       = SW'(err_count) + SW'(popcount(mismatch));
        err_next  = sum > SW'(ERR_MAX) ? ERR_MAX : ERR_W'(sum);
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state     <= IDLE;
            pat_idx   <= '0;
            cnt       <= '0;
            inv_in    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_mask <= '0;
            result    <= RES_IDLE;
`ifdef SKULLFET_ARRAY_TESTER_FIRST_FAIL_EN
            first_fail_pat <= '1;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= DRIVE;
                        pat_idx   <= '0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_mask <= '0;
                        result    <= RES_BUSY;
`ifdef SKULLFET_ARRAY_TESTER_FIRST_FAIL_EN
                        first_fail_pat <= '1;
`endif
                    end
                end
                DRIVE: begin
                    inv_in <= pattern(pat_idx);
                    cnt    <= CNW'(SETTLE_CYCLES - 1);
                    state  <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == '0) state <= CHECK;
                    else cnt <= cnt - 1'b1;
                end
                CHECK: begin
                    err_count <= err_next;
                    fail_mask <= mask_next;
`ifdef SKULLFET_ARRAY_TESTER_FIRST_FAIL_EN
                    if (first_fail_pat == '1 && mismatch != '0) first_fail_pat <= pat_idx;
`endif
                    if (pat_idx == PAT_W'(NUM_PAT - 1)) begin
                        state  <= DONE;
                        inv_in <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        pass   <= mask_next == '0;
                        result <= mask_next == '0 ? RES_PASS : RES_FAIL;
                    end else begin
                        pat_idx <= pat_idx + 1'b1;
                        state   <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
